// File: rtl/as_gpio_sig_monitor.sv
// GPIO write-bus signature monitor: checks snooped writes, in order, against a loadable expected table.
// Optional build macro AS_GPIOMON_SKIPZERO_EN: in-window zero-data writes are ignored while running.
module as_gpio_sig_monitor #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 8,
  parameter int NUM_CH      = 2,
  parameter int BASE_ADDR   = 4,
  parameter int SEQ_DEPTH   = 64,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          cs_i,
  input  logic [ADDR_W-1:0]                             gpioAddr_i,
  input  logic [DATA_W-1:0]                             gpio_i,
  input  logic                                          ld_we_i,
  input  logic [$clog2(SEQ_DEPTH)-1:0]                  ld_idx_i,
  input  logic [$clog2((NUM_CH > 2) ? NUM_CH : 2)-1:0]  ld_ch_i,
  input  logic [DATA_W-1:0]                             ld_data_i,
  input  logic                                          ld_last_i,
  input  logic                                          start_i,
  input  logic                                          clear_i,
  output logic                                          busy_o,
  output logic                                          pass_o,
  output logic                                          fail_o,
  output logic [1:0]                                    fail_cause_o,
  output logic [$clog2(SEQ_DEPTH)-1:0]                  fail_idx_o,
  output logic [DATA_W-1:0]                             fail_data_o,
  output logic [$clog2(SEQ_DEPTH):0]                    match_cnt_o
);

  localparam int IDX_W   = $clog2(SEQ_DEPTH);
  localparam int CH_W    = $clog2((NUM_CH > 2) ? NUM_CH : 2);
  localparam int CNT_W   = IDX_W + 1;
  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0]    WIN_LO    = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0]    WIN_HI    = (ADDR_W+1)'(BASE_ADDR + NUM_CH - 1);

  localparam logic [1:0] CAUSE_MISMATCH = 2'd0;
  localparam logic [1:0] CAUSE_BAD_ADDR = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_EMPTY    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  // Expected-signature table
  logic [CH_W-1:0]   tbl_ch   [SEQ_DEPTH];
  logic [DATA_W-1:0] tbl_data [SEQ_DEPTH];

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cause_q, cause_d;
  logic [IDX_W-1:0]   fidx_q, fidx_d;
  logic [DATA_W-1:0]  fdata_q, fdata_d;
  logic [IDX_W-1:0]   len_last_q, len_last_d;
  logic               len_valid_q, len_valid_d;

  logic [ADDR_W:0]    addr_ext;
  logic               in_window;
  logic [CH_W-1:0]    wr_ch;
  logic               entry_hit;
  logic               zero_skip;
  logic               load_en;

  // Extra top bit keeps the window bounds from wrapping when BASE_ADDR sits near the top of the map.
  assign addr_ext  = {1'b0, gpioAddr_i};
  assign in_window = (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI);
  assign wr_ch     = CH_W'(gpioAddr_i - ADDR_W'(BASE_ADDR));
  assign entry_hit = (wr_ch == tbl_ch[idx_q]) && (gpio_i == tbl_data[idx_q]);
  assign load_en   = (state_q == S_IDLE) && ld_we_i;

`ifdef AS_GPIOMON_SKIPZERO_EN
  assign zero_skip = in_window && (gpio_i == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // NOTE: the table carries no reset; the length-valid flag alone decides whether its contents are trusted.
  always_ff @(posedge clk_i) begin
    if (load_en) begin
      tbl_ch[ld_idx_i]   <= ld_ch_i;
      tbl_data[ld_idx_i] <= ld_data_i;
    end
  end

  // Length tracking; start in the same cycle as a load sees the updated value.
  always_comb begin
    len_last_d  = len_last_q;
    len_valid_d = len_valid_q;
    if (load_en) begin
      if (ld_last_i) begin
        len_last_d  = ld_idx_i;
        len_valid_d = 1'b1;
      end else if (ld_idx_i == len_last_q) begin
        len_valid_d = 1'b0;
      end
    end
  end

  // NOTE: every combinational output is given its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    fidx_d  = fidx_q;
    fdata_d = fdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
          if (len_valid_d) begin
            state_d = S_RUN;
          end else begin
            state_d = S_FAIL;
            cause_d = CAUSE_EMPTY;
            fidx_d  = '0;
            fdata_d = '0;
          end
        end
      end

      S_RUN: begin
        if (cs_i && !in_window) begin
          state_d = S_FAIL;
          cause_d = CAUSE_BAD_ADDR;
          fidx_d  = idx_q;
          fdata_d = gpio_i;
        end else if (cs_i && !zero_skip) begin
          if (entry_hit) begin
            cnt_d   = cnt_q + CNT_W'(1);
            timer_d = '0;
            if (idx_q == len_last_q) begin
              state_d = S_PASS;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            state_d = S_FAIL;
            cause_d = CAUSE_MISMATCH;
            fidx_d  = idx_q;
            fdata_d = gpio_i;
          end
        end else if (timer_q == TIMER_MAX) begin
          // A write in this same cycle took the branch above, so expiry only fires on a truly idle cycle.
          state_d = S_FAIL;
          cause_d = CAUSE_TIMEOUT;
          fidx_d  = idx_q;
          fdata_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      S_PASS, S_FAIL: begin
        if (clear_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
          timer_d = '0;
          cnt_d   = '0;
          cause_d = '0;
          fidx_d  = '0;
          fdata_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      cnt_q       <= '0;
      cause_q     <= '0;
      fidx_q      <= '0;
      fdata_q     <= '0;
      len_last_q  <= '0;
      len_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      fidx_q      <= fidx_d;
      fdata_q     <= fdata_d;
      len_last_q  <= len_last_d;
      len_valid_q <= len_valid_d;
    end
  end

  assign busy_o       = (state_q == S_RUN);
  assign pass_o       = (state_q == S_PASS);
  assign fail_o       = (state_q == S_FAIL);
  assign fail_cause_o = cause_q;
  assign fail_idx_o   = fidx_q;
  assign fail_data_o  = fdata_q;
  assign match_cnt_o  = cnt_q;

endmodule

// File: tb/tb_as_gpio_sig_monitor.sv
// Self-checking bench for as_gpio_sig_monitor: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_as_gpio_sig_monitor;

  localparam int DATA_W      = 64;
  localparam int ADDR_W      = 8;
  localparam int NUM_CH      = 2;
  localparam int BASE_ADDR   = 4;
  localparam int SEQ_DEPTH   = 64;
  localparam int TIMEOUT_CYC = 10;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cs_i;
  logic [7:0]        gpioAddr_i;
  logic [63:0]       gpio_i;
  logic              ld_we_i;
  logic [5:0]        ld_idx_i;
  logic [0:0]        ld_ch_i;
  logic [63:0]       ld_data_i;
  logic              ld_last_i;
  logic              start_i;
  logic              clear_i;
  logic              busy_o;
  logic              pass_o;
  logic              fail_o;
  logic [1:0]        fail_cause_o;
  logic [5:0]        fail_idx_o;
  logic [63:0]       fail_data_o;
  logic [6:0]        match_cnt_o;

  as_gpio_sig_monitor #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .BASE_ADDR(BASE_ADDR),
    .SEQ_DEPTH(SEQ_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .gpioAddr_i(gpioAddr_i), .gpio_i(gpio_i),
    .ld_we_i(ld_we_i), .ld_idx_i(ld_idx_i), .ld_ch_i(ld_ch_i), .ld_data_i(ld_data_i),
    .ld_last_i(ld_last_i), .start_i(start_i), .clear_i(clear_i),
    .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o), .fail_cause_o(fail_cause_o),
    .fail_idx_o(fail_idx_o), .fail_data_o(fail_data_o), .match_cnt_o(match_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode, m_len, m_pos, m_matched, m_idle, m_cause, m_fidx;
  logic [63:0] m_fdata;
  int          m_ch [SEQ_DEPTH];
  logic [63:0] m_d  [SEQ_DEPTH];
  int          m_addr;
  bit          m_in_win, m_ignored;

  task automatic model_fail(input int cause, input logic [63:0] data);
    m_mode  = M_FAIL;
    m_cause = cause;
    m_fidx  = m_pos;
    m_fdata = data;
  endtask

  task automatic model_zero();
    m_pos = 0; m_matched = 0; m_idle = 0; m_cause = 0; m_fidx = 0; m_fdata = '0;
  endtask

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_mode = M_IDLE;
      m_len  = 0;
      model_zero();
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ld_we_i) begin
            m_ch[ld_idx_i] = int'(ld_ch_i);
            m_d[ld_idx_i]  = ld_data_i;
            if (ld_last_i) m_len = int'(ld_idx_i) + 1;
            else if (int'(ld_idx_i) == m_len - 1) m_len = 0;
          end
          if (start_i) begin
            model_zero();
            if (m_len == 0) model_fail(3, '0);
            else m_mode = M_RUN;
          end
        end
        M_RUN: begin
          m_addr   = int'(gpioAddr_i);
          m_in_win = (m_addr >= BASE_ADDR) && (m_addr < BASE_ADDR + NUM_CH);
`ifdef AS_GPIOMON_SKIPZERO_EN
          m_ignored = m_in_win && (gpio_i == 64'd0);
`else
          m_ignored = 1'b0;
`endif
          if (cs_i && !m_in_win) begin
            model_fail(1, gpio_i);
          end else if (cs_i && !m_ignored) begin
            if ((m_addr - BASE_ADDR) == m_ch[m_pos] && gpio_i == m_d[m_pos]) begin
              m_matched++;
              m_pos++;
              m_idle = 0;
              if (m_pos == m_len) m_mode = M_PASS;
            end else begin
              model_fail(0, gpio_i);
            end
          end else begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC) model_fail(2, '0);
          end
        end
        default: begin
          if (clear_i) begin
            m_mode = M_IDLE;
            model_zero();
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("cyc.busy",       64'(busy_o),       64'(m_mode == M_RUN));
      check("cyc.pass",       64'(pass_o),       64'(m_mode == M_PASS));
      check("cyc.fail",       64'(fail_o),       64'(m_mode == M_FAIL));
      check("cyc.fail_cause", 64'(fail_cause_o), 64'(m_cause));
      check("cyc.fail_idx",   64'(fail_idx_o),   64'(m_fidx));
      check("cyc.fail_data",  fail_data_o,       m_fdata);
      check("cyc.match_cnt",  64'(match_cnt_o),  64'(m_matched));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive_idle();
    rst_i = 1'b0; cs_i = 1'b0; gpioAddr_i = '0; gpio_i = '0;
    ld_we_i = 1'b0; ld_idx_i = '0; ld_ch_i = '0; ld_data_i = '0; ld_last_i = 1'b0;
    start_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_load(input int idx, input int ch, input logic [63:0] data, input bit last);
    ld_we_i = 1'b1; ld_idx_i = 6'(idx); ld_ch_i = 1'(ch); ld_data_i = data; ld_last_i = last;
    tick();
    ld_we_i = 1'b0; ld_last_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [63:0] data);
    cs_i = 1'b1; gpioAddr_i = 8'(addr); gpio_i = data;
    tick();
    cs_i = 1'b0; gpioAddr_i = '0; gpio_i = '0;
  endtask

  task automatic expect_outs(input string tag, input bit busy, input bit pass, input bit fail,
                             input int cause, input int idx, input logic [63:0] data, input int cnt);
    check({tag, ".busy"},       64'(busy_o),       64'(busy));
    check({tag, ".pass"},       64'(pass_o),       64'(pass));
    check({tag, ".fail"},       64'(fail_o),       64'(fail));
    check({tag, ".fail_cause"}, 64'(fail_cause_o), 64'(cause));
    check({tag, ".fail_idx"},   64'(fail_idx_o),   64'(idx));
    check({tag, ".fail_data"},  fail_data_o,       data);
    check({tag, ".match_cnt"},  64'(match_cnt_o),  64'(cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog expired");
  end

  int r, len;

  initial begin
    drive_idle();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    cmp_en = 1'b1;
    expect_outs("reset", 0, 0, 0, 0, 0, 64'd0, 0);

    // Fill the whole table so no entry is ever undefined; length stays invalid.
    for (int i = 0; i < SEQ_DEPTH; i++) do_load(i, 0, 64'(1000 + i), 1'b0);

    // Start with no valid length -> empty table failure, then clear.
    do_reset();
    do_start();
    expect_outs("empty", 0, 0, 1, 3, 0, 64'd0, 0);
    do_clear();
    expect_outs("empty_clr", 0, 0, 0, 0, 0, 64'd0, 0);

    // Four-entry pass.
    do_load(0, 0, 64'd17, 0); do_load(1, 0, 64'd7, 0);
    do_load(2, 0, 64'd5, 0);  do_load(3, 0, 64'd8, 1);
    do_start();
    do_write(4, 64'd17); do_write(4, 64'd7); do_write(4, 64'd5);
    expect_outs("seq4_mid", 1, 0, 0, 0, 0, 64'd0, 3);
    do_write(4, 64'd8);
    expect_outs("seq4_pass", 0, 1, 0, 0, 0, 64'd0, 4);
    do_write(4, 64'd99);
    expect_outs("seq4_hold", 0, 1, 0, 0, 0, 64'd0, 4);
    do_clear();

    // Same table, mismatch on second entry.
    do_start();
    do_write(4, 64'd17); do_write(4, 64'd6);
    expect_outs("mismatch", 0, 0, 1, 0, 1, 64'd6, 1);
    do_start();
    expect_outs("start_ignored", 0, 0, 1, 0, 1, 64'd6, 1);
    do_clear();

    // Channel 1 entry: correct address passes, out-of-window address fails.
    do_load(0, 1, 64'hAA, 1);
    do_start();
    do_write(5, 64'hAA);
    expect_outs("ch1_pass", 0, 1, 0, 0, 0, 64'd0, 1);
    do_clear();
    do_start();
    do_write(7, 64'hAA);
    expect_outs("bad_addr", 0, 0, 1, 1, 0, 64'hAA, 0);
    do_clear();

    // Timeout exactly TIMEOUT_CYC cycles after start; a write on the expiry cycle wins.
    do_load(0, 0, 64'd3, 0); do_load(1, 0, 64'd4, 1);
    do_start();
    repeat (TIMEOUT_CYC - 1) tick();
    expect_outs("to_before", 1, 0, 0, 0, 0, 64'd0, 0);
    tick();
    expect_outs("to_fire", 0, 0, 1, 2, 0, 64'd0, 0);
    do_clear();
    do_start();
    repeat (TIMEOUT_CYC - 1) tick();
    do_write(4, 64'd3);
    expect_outs("to_write_wins", 1, 0, 0, 0, 0, 64'd0, 1);
    repeat (TIMEOUT_CYC - 1) tick();
    expect_outs("to_restart_before", 1, 0, 0, 0, 0, 64'd0, 1);
    tick();
    expect_outs("to_restart_fire", 0, 0, 1, 2, 1, 64'd0, 1);
    do_clear();

    // Zero-data write against a non-zero entry.
    do_load(0, 0, 64'd8, 1);
    do_start();
    do_write(4, 64'd0);
`ifdef AS_GPIOMON_SKIPZERO_EN
    do_write(4, 64'd0);
    do_write(4, 64'd8);
    expect_outs("zero_skip", 0, 1, 0, 0, 0, 64'd0, 1);
`else
    expect_outs("zero_cmp", 0, 0, 1, 0, 0, 64'd0, 0);
`endif
    do_clear();

    // Load and start in the same cycle.
    ld_we_i = 1'b1; ld_idx_i = 6'd0; ld_ch_i = 1'b0; ld_data_i = 64'd9; ld_last_i = 1'b1; start_i = 1'b1;
    tick();
    drive_idle();
    expect_outs("ld_start", 1, 0, 0, 0, 0, 64'd0, 0);
    do_write(4, 64'd9);
    expect_outs("ld_start_pass", 0, 1, 0, 0, 0, 64'd0, 1);
    do_clear();
    ld_we_i = 1'b1; ld_idx_i = 6'd0; ld_data_i = 64'd9; ld_last_i = 1'b0; start_i = 1'b1;
    tick();
    drive_idle();
    expect_outs("ld_invalidate", 0, 0, 1, 3, 0, 64'd0, 0);
    do_clear();

    // Reset mid-run aborts and invalidates the length.
    do_load(0, 0, 64'd5, 1);
    do_start();
    do_reset();
    expect_outs("rst_run", 0, 0, 0, 0, 0, 64'd0, 0);
    do_start();
    expect_outs("rst_len", 0, 0, 1, 3, 0, 64'd0, 0);
    do_clear();

    // ---------------- randomized traffic ----------------
    for (int it = 0; it < 80; it++) begin
      drive_idle();
      if (m_mode == M_RUN) do_reset();
      else if (m_mode != M_IDLE) do_clear();
      if ($urandom_range(0, 9) != 0) begin
        len = $urandom_range(1, 5);
        for (int e = 0; e < len; e++) begin
          do_load(e, $urandom_range(0, 1), 64'($urandom_range(0, 3)), e == len - 1);
          if ($urandom_range(0, 3) == 0) tick();
        end
      end
      do_start();
      for (int c = 0; c < 45 && m_mode == M_RUN; c++) begin
        drive_idle();
        r = $urandom_range(0, 99);
        if (r < 45) begin
          cs_i = 1'b1; gpioAddr_i = 8'(BASE_ADDR + m_ch[m_pos]); gpio_i = m_d[m_pos];
        end else if (r < 57) begin
          cs_i = 1'b1; gpioAddr_i = 8'(BASE_ADDR + $urandom_range(0, 1)); gpio_i = 64'($urandom_range(0, 3));
        end else if (r < 62) begin
          cs_i = 1'b1; gpio_i = {32'($urandom), 32'($urandom)};
          case ($urandom_range(0, 3))
            0:       gpioAddr_i = 8'd3;
            1:       gpioAddr_i = 8'd6;
            2:       gpioAddr_i = 8'd255;
            default: gpioAddr_i = 8'($urandom_range(6, 255));
          endcase
        end
        if ($urandom_range(0, 19) == 0) start_i = 1'b1;
        if ($urandom_range(0, 19) == 0) clear_i = 1'b1;
        if ($urandom_range(0, 19) == 0) begin
          ld_we_i = 1'b1; ld_idx_i = 6'($urandom_range(0, 7)); ld_ch_i = 1'($urandom_range(0, 1));
          ld_data_i = 64'($urandom_range(0, 3)); ld_last_i = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 199) == 0) rst_i = 1'b1;
        tick();
      end
      for (int p = 0; p < 3; p++) begin
        drive_idle();
        cs_i = 1'($urandom_range(0, 1));
        gpioAddr_i = 8'($urandom_range(3, 6));
        gpio_i = 64'($urandom_range(0, 3));
        start_i = ($urandom_range(0, 3) == 0);
        tick();
      end
    end

    drive_idle();
    repeat (2) tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/as_gpio_sig_monitor.md
Name: as_gpio_sig_monitor

Overview:
- Synthesizable on-chip self-test monitor that snoops the core's GPIO write bus (cs, address, data).
- Compares each write, in order, against a loadable expected-signature table. Reports pass, fail, timeout, cause and progress counters.
- Replaces the simulation-only code checking with a parametrised, multi-channel block that can run on silicon or FPGA. Sits beside the top-level memory/GPIO decode.

Parameters:
- DATA_W, 64, width of GPIO data bus.
- ADDR_W, 8, width of GPIO address bus.
- NUM_CH, 2, number of monitored channels; channel k lives at address BASE_ADDR+k.
- BASE_ADDR, 4, GPIO address of channel 0.
- SEQ_DEPTH, 64, entries in the expected-signature table (power of two).
- TIMEOUT_CYC, 100000, maximum idle cycles between accepted writes while running (must be ≥1).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cs_i  in  1  GPIO write strobe, one cycle per write.
- gpioAddr_i  in  ADDR_W  GPIO write address.
- gpio_i  in  DATA_W  GPIO write data.
- ld_we_i  in  1  table load strobe; honoured only in IDLE.
- ld_idx_i  in  log2(SEQ_DEPTH)  table entry index.
- ld_ch_i  in  log2(max(NUM_CH,2))  expected channel for the entry.
- ld_data_i  in  DATA_W  expected data for the entry.
- ld_last_i  in  1  marks this entry as the final one; sequence length = ld_idx_i+1.
- start_i  in  1  IDLE→RUN.
- clear_i  in  1  PASS/FAIL→IDLE; table is retained.
- busy_o  out  1  high in RUN.
- pass_o  out  1  high in PASS.
- fail_o  out  1  high in FAIL.
- fail_cause_o  out  2  0 mismatch, 1 bad address, 2 timeout, 3 empty table.
- fail_idx_o  out  log2(SEQ_DEPTH)  table index being checked at failure.
- fail_data_o  out  DATA_W  offending write data (0 for timeout or empty).
- match_cnt_o  out  log2(SEQ_DEPTH)+1  number of entries matched so far.

Behaviour:
- Reset: state IDLE; all outputs 0; length register invalid; table contents don't-care.
- Table load: a write occurs when ld_we_i=1 in IDLE. The most recent load with ld_last_i=1 sets the length. A later load with ld_last_i=0 at the same index clears the length valid flag. Loads outside IDLE are ignored.
- States:
  - IDLE: start_i → RUN with idx=0, match_cnt=0, timer=0. If the length is invalid, go to FAIL with cause 3 instead.
  - RUN: evaluate cs_i/gpioAddr_i/gpio_i each cycle.
    - Address outside [BASE_ADDR, BASE_ADDR+NUM_CH-1] with cs_i=1 → FAIL, cause 1.
    - In-window write whose channel and data both equal table[idx] → match_cnt+1, idx+1, timer=0. If idx was the last entry → PASS.
    - In-window write that does not match → FAIL, cause 0.
    - No write → timer+1. When timer reaches TIMEOUT_CYC-1 and no write is present → FAIL, cause 2.
  - PASS/FAIL: bus activity is ignored. clear_i → IDLE with outputs zeroed, except the table and length, which are kept.
- Latency: a write sampled on edge N updates state and outputs after edge N; they are visible in cycle N+1. Fail info registers are captured on the same edge as the FAIL transition.
- Simultaneous events:
  - A write on the same cycle the timer expires is evaluated as a write; it is not a timeout.
  - start_i and ld_we_i together: the load is applied and start uses the updated length.
  - clear_i outside PASS/FAIL is ignored. start_i outside IDLE is ignored.
- rst_i mid-RUN aborts immediately to IDLE and invalidates the length.
- Address compare uses the full ADDR_W, unsigned. Channel = gpioAddr_i − BASE_ADDR.

Optional Feature:
- Macro: AS_GPIOMON_SKIPZERO_EN.
- Defined: in-window writes with gpio_i==0 in RUN are ignored. They are not compared and do not reset the timer, which targets spurious zero writes.
- Undefined: zero-data writes are compared like any other value.

Test Plan:
- Load [ch0:17, ch0:7, ch0:5, ch0:8(last)], start, write 17,7,5,8 to addr 4 → pass_o=1 one cycle after the 8 write; match_cnt_o=4; fail_o=0.
- Same table, write 17 then 6 → fail_o=1, fail_cause_o=0, fail_idx_o=1, fail_data_o=6, match_cnt_o=1.
- NUM_CH=2: load [ch1:0xAA(last)], write 0xAA to addr 5 → PASS. Repeat with the write to addr 7 → FAIL, cause 1, fail_data_o=0xAA.
- TIMEOUT_CYC=10, start, no writes → fail_o rises exactly 10 cycles after start; cause 2. A write on cycle 9 instead → no fail; the timer restarts.
- Reset, then start with no load → FAIL, cause 3. clear_i → IDLE, outputs 0.
- Macro on, table [ch0:8(last)], writes 0, 0, 8 → PASS. Macro off → FAIL, cause 0, fail_data_o=0, fail_idx_o=0.
